decompressor: RTL
=================

DECOMPRESSOR -- requirements
Module: decompressor

Interface
REQ-001 SHALL have parameter FIFO_PTR_WIDTH, default 6, width of read-FIFO pointer in debug output.
REQ-002 SHALL have parameter DATA_WIDTH, default `HACD_AXI4_DATA_WIDTH, cache-line width in bits.
REQ-003 SHALL have ports (one clock; reset asynchronous, active-high):
 clk_i  in  1  clock
 rst_i  in  1  asynchronous active-high reset
 decomp_start  in  1  level request to expand one compressed page
 rdfifo_empty  in  1  compressed-line FIFO empty
 rd_req  out  1  one-cycle read request to FIFO
 rd_data  in  DATA_WIDTH  returned line
 rd_rresp  in  2  response code, 0 = OK
 rd_valid  in  1  rd_data/rd_rresp valid
 wrfifo_full  in  1  output FIFO full
 wr_req  out  1  one-cycle write strobe
 wr_data  out  DATA_WIDTH  expanded line
 decomp_done  out  1  page expanded; held while decomp_start high
 format_err  out  1  metadata invalid; sticky
 bus_err  out  1  nonzero rd_rresp seen; sticky
 debug_decomp  out  debug_decompressor  state, line_cnt, chunk_vec, outstanding

Function
REQ-004 Input format: line 0 = metadata, bits[3:0] = zero-chunk vector (bit i set => chunk i, lines 16i..16i+15, all zero), upper bits ignored; followed by exactly 16 data lines.
REQ-005 Output: exactly 64 lines written in address order 0..63; zero chunk -> 16 all-zero lines; non-zero chunk -> the 16 data lines in arrival order.
REQ-006 States: IDLE, META_RD, META_WAIT, CHECK, ZERO_WR, DATA_RD, DATA_WAIT, DATA_WR, DRAIN_RD, DRAIN_WAIT, DONE, FMT_ERR, BUS_ERR.
REQ-007 IDLE -> META_RD when decomp_start=1 and rdfifo_empty=0; clears line_cnt (7 bit) and drain count.
REQ-008 At most one read outstanding; rd_req asserted only in *_RD states with rdfifo_empty=0, next state *_WAIT.
REQ-009 rd_valid outside a *_WAIT state SHALL be ignored.
REQ-010 *_WAIT with rd_valid and rd_rresp!=0 -> BUS_ERR; bus_err=1 until reset.
REQ-011 META_WAIT with rd_valid, rresp=0: latch bits[3:0] into chunk_vec -> CHECK.
REQ-012 CHECK: popcount(chunk_vec)<3 -> FMT_ERR (format_err=1 until reset, no writes); else chunk_vec[line_cnt[5:4]] ? ZERO_WR : DATA_RD.
REQ-013 ZERO_WR: each cycle with wrfifo_full=0 issue wr_req with wr_data=0, line_cnt+1; at chunk boundary re-evaluate per REQ-012 chunk select.
REQ-014 DATA_WAIT with valid OK response: register line into holding register -> DATA_WR; DATA_WR issues write when wrfifo_full=0, line_cnt+1, then DATA_RD or next chunk.
REQ-015 wr_req/wr_data registered: write presented the cycle after the decision; wrfifo_full=1 stalls with no write and no counter change.
REQ-016 line_cnt reaching 64: chunk_vec==4'hF -> DRAIN_RD (read and discard 16 trailing lines, no writes), else DONE.
REQ-017 DONE: decomp_done=1 registered while decomp_start=1; decomp_start=0 -> IDLE, decomp_done=0 next cycle.
REQ-018 decomp_start deassertion before DONE SHALL be ignored; page completes.
REQ-019 rdfifo_empty=1 in *_RD: wait, no request.

Reset
REQ-020 rst_i=1 asynchronously forces IDLE, rd_req=0, wr_req=0, wr_data=0, decomp_done=0, format_err=0, bus_err=0, counters and chunk_vec 0, including mid-page; no partial-page recovery.

Structure
REQ-021 hacd_pkg SHALL hold debug_decompressor struct, state encoding, LINES_PER_CHUNK=16, CHUNKS_PER_PAGE=4, MIN_ZERO_CHUNKS=3.
REQ-022 Single module, no sub-modules; two-process FSM (combinational next-state, registered outputs).

Verification
REQ-023 vec=4'b1110, 16 lines 0x1..0x10, full never -> 64 writes, lines 0-15 = 0x1..0x10, 16-63 zero, decomp_done.
REQ-024 vec=4'b1011 -> lines 0-31 zero, 32-47 data, 48-63 zero; exactly 17 reads.
REQ-025 vec=4'hF -> 64 zero writes, 17 reads total, trailing 16 discarded.
REQ-026 vec=4'b0011 -> format_err=1, zero writes, stays FMT_ERR until rst_i.
REQ-027 rd_rresp=2 on 5th data line -> bus_err=1, exactly 4 data writes issued after any zero writes.
REQ-028 wrfifo_full toggled randomly plus rst_i pulse mid-page -> no write while full, all outputs 0 after reset, next page correct.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared definitions for the page decompressor.
// Contents:
//   - cache-line width default macro (HACD_AXI4_DATA_WIDTH)
//   - page geometry: LINES_PER_CHUNK, CHUNKS_PER_PAGE, MIN_ZERO_CHUNKS
//   - decomp_state_e FSM state encoding
//   - debug_decompressor debug bundle
//   - popcount4 / state_after_write helpers used by the FSM
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

package hacd_pkg;

    localparam int unsigned LINES_PER_CHUNK = 16;
    localparam int unsigned CHUNKS_PER_PAGE = 4;
    localparam int unsigned MIN_ZERO_CHUNKS = 3;
    localparam int unsigned LINES_PER_PAGE  = LINES_PER_CHUNK * CHUNKS_PER_PAGE;
    localparam int unsigned DBG_PTR_WIDTH   = 6;

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StMetaRd    = 4'd1,
        StMetaWait  = 4'd2,
        StCheck     = 4'd3,
        StZeroWr    = 4'd4,
        StDataRd    = 4'd5,
        StDataWait  = 4'd6,
        StDataWr    = 4'd7,
        StDrainRd   = 4'd8,
        StDrainWait = 4'd9,
        StDone      = 4'd10,
        StFmtErr    = 4'd11,
        StBusErr    = 4'd12
    } decomp_state_e;

    typedef struct packed {
        decomp_state_e              state;
        logic [6:0]                 line_cnt;
        logic [3:0]                 chunk_vec;
        logic                       outstanding;
        logic [DBG_PTR_WIDTH-1:0]   rd_ptr;
    } debug_decompressor;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Where to go once a line has been written and the count has advanced to cnt.
    // An all-zero page still carries 16 trailing data lines, which must be drained.
    function automatic decomp_state_e state_after_write(input logic [6:0] cnt,
                                                        input logic [3:0] vec);
        if (cnt == 7'(LINES_PER_PAGE)) begin
            return (vec == 4'hF) ? StDrainRd : StDone;
        end
        return vec[cnt[5:4]] ? StZeroWr : StDataRd;
    endfunction

endpackage

// File: rtl/decompressor.sv
// Page decompressor: reads one compressed page (metadata line + 16 data lines)
// from a read FIFO and writes the 64-line expanded page to a write FIFO.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   decomp_start            level request to expand one page
//   rdfifo_empty, rd_req    read FIFO status / one-cycle read request
//   rd_data, rd_rresp,
//   rd_valid                returned line, response code (0 = OK), valid
//   wrfifo_full, wr_req,
//   wr_data                 write FIFO status / registered write strobe and line
//   decomp_done             page finished, held while decomp_start stays high
//   format_err, bus_err     sticky error flags, cleared only by reset
//   debug_decomp            state, line count, chunk vector, outstanding, read pointer
module decompressor
    import hacd_pkg::*;
#(
    parameter int unsigned FIFO_PTR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH     = `HACD_AXI4_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  decomp_start,
    input  logic                  rdfifo_empty,
    output logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [1:0]            rd_rresp,
    input  logic                  rd_valid,
    input  logic                  wrfifo_full,
    output logic                  wr_req,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  decomp_done,
    output logic                  format_err,
    output logic                  bus_err,
    output debug_decompressor     debug_decomp
);

    decomp_state_e           state_q, state_d;
    logic [6:0]              line_cnt_q, line_cnt_d;
    logic [3:0]              drain_cnt_q, drain_cnt_d;
    logic [3:0]              chunk_vec_q, chunk_vec_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    wr_req_q, wr_req_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    done_q, done_d;
    logic                    fmt_err_q, fmt_err_d;
    logic                    bus_err_q, bus_err_d;
    logic [FIFO_PTR_WIDTH-1:0] rd_ptr_q;
    logic [6:0]              line_cnt_inc;

    assign line_cnt_inc = line_cnt_q + 7'd1;

    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        drain_cnt_d = drain_cnt_q;
        chunk_vec_d = chunk_vec_q;
        hold_d      = hold_q;
        wr_req_d    = 1'b0;
        wr_data_d   = '0;
        done_d      = 1'b0;
        fmt_err_d   = fmt_err_q;
        bus_err_d   = bus_err_q;
        rd_req      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (decomp_start && !rdfifo_empty) begin
                    state_d     = StMetaRd;
                    line_cnt_d  = '0;
                    drain_cnt_d = '0;
                    chunk_vec_d = '0;
                end
            end
            StMetaRd: begin
                if (!rdfifo_empty) begin
                    rd_req  = 1'b1;
                    state_d = StMetaWait;
                end
            end
            StMetaWait: begin
                if (rd_valid) begin
                    if (rd_rresp != 2'd0) begin
                        state_d   = StBusErr;
                        bus_err_d = 1'b1;
                    end else begin
                        chunk_vec_d = rd_data[3:0];
                        state_d     = StCheck;
                    end
                end
            end
            StCheck: begin
                if (popcount4(chunk_vec_q) < 3'(MIN_ZERO_CHUNKS)) begin
                    state_d   = StFmtErr;
                    fmt_err_d = 1'b1;
                end else begin
                    state_d = chunk_vec_q[line_cnt_q[5:4]] ? StZeroWr : StDataRd;
                end
            end
            StZeroWr: begin
                if (!wrfifo_full) begin
                    wr_req_d   = 1'b1;
                    line_cnt_d = line_cnt_inc;
                    state_d    = state_after_write(line_cnt_inc, chunk_vec_q);
                end
            end
            StDataRd: begin
                if (!rdfifo_empty) begin
                    rd_req  = 1'b1;
                    state_d = StDataWait;
                end
            end
            StDataWait: begin
                if (rd_valid) begin
                    if (rd_rresp != 2'd0) begin
                        state_d   = StBusErr;
                        bus_err_d = 1'b1;
                    end else begin
                        hold_d  = rd_data;
                        state_d = StDataWr;
                    end
                end
            end
            StDataWr: begin
                if (!wrfifo_full) begin
                    wr_req_d   = 1'b1;
                    wr_data_d  = hold_q;
                    line_cnt_d = line_cnt_inc;
                    state_d    = state_after_write(line_cnt_inc, chunk_vec_q);
                end
            end
            StDrainRd: begin
                if (!rdfifo_empty) begin
                    rd_req  = 1'b1;
                    state_d = StDrainWait;
                end
            end
            StDrainWait: begin
                if (rd_valid) begin
                    if (rd_rresp != 2'd0) begin
                        state_d   = StBusErr;
                        bus_err_d = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 4'd1;
                        state_d     = (drain_cnt_q == 4'd15) ? StDone : StDrainRd;
                    end
                end
            end
            StDone: begin
                done_d  = decomp_start;
                state_d = decomp_start ? StDone : StIdle;
            end
            StFmtErr: state_d = StFmtErr;
            StBusErr: state_d = StBusErr;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            line_cnt_q  <= '0;
            drain_cnt_q <= '0;
            chunk_vec_q <= '0;
            hold_q      <= '0;
            wr_req_q    <= 1'b0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            fmt_err_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            chunk_vec_q <= chunk_vec_d;
            hold_q      <= hold_d;
            wr_req_q    <= wr_req_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            fmt_err_q   <= fmt_err_d;
            bus_err_q   <= bus_err_d;
            if (rd_req) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign wr_req      = wr_req_q;
    assign wr_data     = wr_data_q;
    assign decomp_done = done_q;
    assign format_err  = fmt_err_q;
    assign bus_err     = bus_err_q;

    assign debug_decomp.state       = state_q;
    assign debug_decomp.line_cnt    = line_cnt_q;
    assign debug_decomp.chunk_vec   = chunk_vec_q;
    assign debug_decomp.outstanding = (state_q == StMetaWait) || (state_q == StDataWait) ||
                                      (state_q == StDrainWait);
    assign debug_decomp.rd_ptr      = DBG_PTR_WIDTH'(rd_ptr_q);

endmodule
